// File: rtl/calc_display_seq_pkg.sv
// Shared definitions for the sequential calculator: op codes, FSM states,
// and active-low 7-segment constants.
package calc_display_seq_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_CONV = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   // bit0 = a .. bit6 = g, a cleared bit lights the segment
   function automatic logic [6:0] seg_digit(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/calc_display_seq_seg7_decode.sv
// One BCD digit to active-low 7-segment pattern; non-decimal codes go blank.
module seg7_decode
   import calc_display_seq_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   assign seg_o = seg_digit(bcd_i);

endmodule

// File: rtl/calc_display_seq.sv
// Iterative ADD/SUB/MUL calculator with double-dabble conversion to a
// multi-digit active-low 7-segment display; last result is held.
module calc_display_seq
   import calc_display_seq_pkg::*;
#(
   parameter int NBITS   = 8,
   parameter int NDIGITS = 5,
   parameter int LZB     = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_val,
   output logic                   in_rdy,
   input  logic [NBITS-1:0]       in0,
   input  logic [NBITS-1:0]       in1,
   input  logic [1:0]             op,
   output logic                   out_val,
   input  logic                   out_rdy,
   output logic [2*NBITS-1:0]     result,
   output logic                   err,
   output logic [7*NDIGITS-1:0]   seg
);

   localparam int RBITS = 2 * NBITS;
   localparam int BW    = 4 * NDIGITS + 4;
   localparam int CW    = $clog2(RBITS + 1);

   logic [1:0]           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [1:0]           op_q, op_d;
   logic [RBITS-1:0]     acc_q, acc_d;
   logic [RBITS-1:0]     mcand_q, mcand_d;
   logic [NBITS-1:0]     mplier_q, mplier_d;
   logic                 uflow_q, uflow_d;
   logic [RBITS-1:0]     bin_q, bin_d;
   logic [BW-1:0]        bcd_q, bcd_d;
   logic                 ovf_q, ovf_d;
   logic [RBITS-1:0]     result_q, result_d;
   logic                 err_q, err_d;
   logic [7*NDIGITS-1:0] seg_q, seg_d;

   logic [RBITS-1:0]     operand1;
   logic [RBITS-1:0]     calc_val;
   logic                 calc_last;
   logic [BW-1:0]        bcd_adj;
   logic [BW-1:0]        bcd_shift;
   logic                 ovf_shift;
   logic                 final_err;
   logic [NDIGITS:0]     nz_from;
   logic [7*NDIGITS-1:0] seg_new;

   assign operand1 = {{NBITS{1'b0}}, mplier_q};

   always_comb begin
      calc_val  = mcand_q + operand1;
      calc_last = 1'b1;
      if (op_q == OP_SUB) begin
         calc_val = mcand_q - operand1;
      end else if (op_q == OP_MUL) begin
         calc_val  = mplier_q[0] ? acc_q + mcand_q : acc_q;
         calc_last = (cnt_q == CW'(NBITS - 1));
      end
   end

   always_comb begin
      bcd_adj = bcd_q;
      for (int k = 0; k < NDIGITS + 1; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) begin
            bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
         end
      end
   end

   // Bits pushed out past the guard digit are remembered, so values needing
   // more than NDIGITS+1 digits still flag overflow.
   assign bcd_shift = {bcd_adj[BW-2:0], bin_q[RBITS-1]};
   assign ovf_shift = ovf_q | bcd_adj[BW-1];
   assign final_err = uflow_q | ovf_shift | (bcd_shift[BW-1 -: 4] != 4'd0);

   assign nz_from[NDIGITS] = 1'b0;
   for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
      logic [3:0] digit;
      logic [6:0] dec;
      logic       show;
      assign digit = bcd_shift[4*gi +: 4];
      seg7_decode u_dec (
         .bcd_i (digit),
         .seg_o (dec)
      );
      assign nz_from[gi] = nz_from[gi+1] | (digit != 4'd0);
      assign show = (gi == 0) || (LZB == 0) || nz_from[gi];
      assign seg_new[7*gi +: 7] = final_err ? SEG_DASH : (show ? dec : SEG_BLANK);
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      uflow_d  = uflow_q;
      bin_d    = bin_q;
      bcd_d    = bcd_q;
      ovf_d    = ovf_q;
      result_d = result_q;
      err_d    = err_q;
      seg_d    = seg_q;
      case (state_q)
         ST_IDLE: begin
            if (in_val) begin
               op_d     = op;
               mcand_d  = {{NBITS{1'b0}}, in0};
               mplier_d = in1;
               acc_d    = '0;
               cnt_d    = '0;
               uflow_d  = 1'b0;
               state_d  = ST_CALC;
            end
         end
         ST_CALC: begin
            acc_d    = calc_val;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (op_q == OP_SUB) begin
               uflow_d = mplier_q > mcand_q[NBITS-1:0];
            end
            if (calc_last) begin
               bin_d   = calc_val;
               bcd_d   = '0;
               ovf_d   = 1'b0;
               cnt_d   = '0;
               state_d = ST_CONV;
            end
         end
         ST_CONV: begin
            bin_d = bin_q << 1;
            bcd_d = bcd_shift;
            ovf_d = ovf_shift;
            cnt_d = cnt_q + 1'b1;
            // Display registers change only here, so nothing flickers mid-computation.
            if (cnt_q == CW'(RBITS - 1)) begin
               result_d = acc_q;
               err_d    = final_err;
               seg_d    = seg_new;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_rdy) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_q     <= OP_ADD;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         uflow_q  <= 1'b0;
         bin_q    <= '0;
         bcd_q    <= '0;
         ovf_q    <= 1'b0;
         result_q <= '0;
         err_q    <= 1'b0;
         seg_q    <= {NDIGITS{SEG_BLANK}};
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         uflow_q  <= uflow_d;
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         ovf_q    <= ovf_d;
         result_q <= result_d;
         err_q    <= err_d;
         seg_q    <= seg_d;
      end
   end

   assign in_rdy  = (state_q == ST_IDLE);
   assign out_val = (state_q == ST_DONE);
   assign result  = result_q;
   assign err     = err_q;
   assign seg     = seg_q;

endmodule

// File: tb/tb_calc_display_seq.sv
// Scoreboard bench: a 5-digit and a 3-digit instance share one stimulus stream
// and are checked against a decimal-arithmetic reference model.
module tb_calc_display_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_val = 1'b0;
   logic        out_rdy = 1'b0;
   logic [7:0]  in0 = '0;
   logic [7:0]  in1 = '0;
   logic [1:0]  op = '0;

   logic        in_rdy, out_val, err;
   logic [15:0] result;
   logic [34:0] seg;
   logic        in_rdy3, out_val3, err3;
   logic [15:0] result3;
   logic [20:0] seg3;

   calc_display_seq dut (
      .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(in_rdy),
      .in0(in0), .in1(in1), .op(op), .out_val(out_val), .out_rdy(out_rdy),
      .result(result), .err(err), .seg(seg)
   );

   calc_display_seq #(.NBITS(8), .NDIGITS(3), .LZB(1)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(in_rdy3),
      .in0(in0), .in1(in1), .op(op), .out_val(out_val3), .out_rdy(out_rdy),
      .result(result3), .err(err3), .seg(seg3)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] res;
      logic        err5;
      logic        err3;
      logic [34:0] seg5;
      logic [20:0] seg3;
      int          lat;
      int          acc_cyc;
   } exp_t;

   exp_t sb[$];
   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   logic [15:0] last_res = '0;
   logic [34:0] last_seg = {5{7'h7F}};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      compared++;
      if (act !== exp_v) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   function automatic logic [34:0] seg_model(input int unsigned v, input bit e, input int nd);
      logic [34:0] s;
      int unsigned p;
      s = '1;
      p = 1;
      for (int i = 0; i < nd; i++) begin
         if (e)                  s[7*i +: 7] = 7'h3F;
         else if (i > 0 && v < p) s[7*i +: 7] = 7'h7F;
         else                    s[7*i +: 7] = tbl[(v / p) % 10];
         p = p * 10;
      end
      return s;
   endfunction

   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o);
      exp_t x;
      int unsigned v;
      bit uf;
      logic [34:0] s3;
      uf = 1'b0;
      case (o)
         2'b01: begin
            v  = (32'(a) + 32'h10000 - 32'(b)) % 32'h10000;
            uf = (b > a);
         end
         2'b10:   v = 32'(a) * 32'(b);
         default: v = 32'(a) + 32'(b);
      endcase
      x.res  = v[15:0];
      x.err5 = uf || (v > 99999);
      x.err3 = uf || (v > 999);
      x.seg5 = seg_model(v, x.err5, 5);
      s3     = seg_model(v, x.err3, 3);
      x.seg3 = s3[20:0];
      x.lat  = (o == 2'b10) ? 24 : 17;
      x.acc_cyc = 0;
      return x;
   endfunction

   // Monitor: one scoreboard pop per rising out_val
   logic ov_prev = 1'b0;
   exp_t mon_e;
   always @(negedge clk) begin
      if (rst_n && out_val && !ov_prev) begin
         if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_out_val: got 1 expected 0 (t=%0t)", $time);
         end else begin
            mon_e = sb.pop_front();
            $display("txn res=%0d err=%0b lat=%0d seg=%h", result, err, cyc - mon_e.acc_cyc, seg);
            chk("latency",  64'(cyc - mon_e.acc_cyc), 64'(mon_e.lat));
            chk("result",   64'(result),   64'(mon_e.res));
            chk("err",      64'(err),      64'(mon_e.err5));
            chk("seg",      64'(seg),      64'(mon_e.seg5));
            chk("out_val3", 64'(out_val3), 64'd1);
            chk("result3",  64'(result3),  64'(mon_e.res));
            chk("err3",     64'(err3),     64'(mon_e.err3));
            chk("seg3",     64'(seg3),     64'(mon_e.seg3));
         end
      end
      ov_prev = out_val;
   end

   task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o, input int stall);
      exp_t e;
      int t;
      @(negedge clk);
      chk("in_rdy_idle", 64'(in_rdy), 64'd1);
      e = model(a, b, o);
      e.acc_cyc = cyc + 1;
      sb.push_back(e);
      in0 = a; in1 = b; op = o; in_val = 1'b1;
      @(negedge clk);
      in_val = 1'b0;
      in0 = 8'($urandom); in1 = 8'($urandom); op = 2'($urandom);
      repeat (3) @(negedge clk);
      chk("hold_result", 64'(result), 64'(last_res));
      chk("hold_seg",    64'(seg),    64'(last_seg));
      chk("busy_in_rdy", 64'(in_rdy), 64'd0);
      t = 0;
      while (!out_val && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!out_val) begin
         compared++;
         mismatched++;
         $display("FAIL out_val_timeout: got 0 expected 1 within 100 cycles");
         void'(sb.pop_front());
      end
      for (int i = 0; i < stall; i++) begin
         in_val = 1'($urandom); in0 = 8'($urandom); in1 = 8'($urandom);
         @(negedge clk);
         chk("stall_out_val", 64'(out_val), 64'd1);
         chk("stall_in_rdy",  64'(in_rdy),  64'd0);
      end
      out_rdy = 1'b1;
      in_val  = 1'b1;
      @(negedge clk);
      out_rdy = 1'b0;
      in_val  = 1'b0;
      chk("ack_out_val", 64'(out_val), 64'd0);
      chk("ack_in_rdy",  64'(in_rdy),  64'd1);
      last_res = e.res;
      last_seg = e.seg5;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] a, b;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_seg_held",  64'(seg),     {29'd0, {5{7'h7F}}});
      chk("rst_outv_held", 64'(out_val), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_rdy",  64'(in_rdy),  64'd1);
      chk("rst_out_val", 64'(out_val), 64'd0);
      chk("rst_result",  64'(result),  64'd0);
      chk("rst_err",     64'(err),     64'd0);
      chk("rst_seg",     64'(seg),     {29'd0, {5{7'h7F}}});
      chk("rst_seg3",    64'(seg3),    {43'd0, {3{7'h7F}}});

      do_txn(8'd17, 8'd25, 2'b00, 0);
      do_txn(8'd255, 8'd255, 2'b10, 1);
      do_txn(8'd3, 8'd9, 2'b01, 0);
      do_txn(8'd9, 8'd9, 2'b01, 2);
      do_txn(8'd40, 8'd30, 2'b10, 5);
      do_txn(8'd200, 8'd100, 2'b11, 0);

      // Reset during a multiply abandons it
      @(negedge clk);
      in0 = 8'd77; in1 = 8'd99; op = 2'b10; in_val = 1'b1;
      @(negedge clk);
      in_val = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_result",  64'(result),  64'd0);
      chk("midrst_err",     64'(err),     64'd0);
      chk("midrst_out_val", 64'(out_val), 64'd0);
      chk("midrst_seg",     64'(seg),     {29'd0, {5{7'h7F}}});
      chk("midrst_seg3",    64'(seg3),    {43'd0, {3{7'h7F}}});
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      last_res = '0;
      last_seg = {5{7'h7F}};
      do_txn(8'd1, 8'd1, 2'b00, 0);

      for (int n = 0; n < 60; n++) begin
         a = ($urandom_range(0, 3) == 0) ? ((($urandom & 1) != 0) ? 8'd255 : 8'd0) : 8'($urandom);
         b = ($urandom_range(0, 3) == 0) ? ((($urandom & 1) != 0) ? 8'd255 : 8'd0) : 8'($urandom);
         do_txn(a, b, 2'($urandom_range(0, 3)), $urandom_range(0, 3));
      end

      repeat (30) @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
